// File: rtl/cop_arb.sv
// Round-robin arbiter sharing one custom-opcode coprocessor between two requesters; one request in flight.
// Latency: cop_valid in the 2nd cycle after the grant edge; rN_ready 1 cycle after cop_ready; reject answered at grant.
// Backpressure: a requester holds rN_valid until its rN_ready pulse; the other waits, ties alternate.
module cop_arb #(
    parameter logic [6:0]       CUSOPCODE = 7'b0001011,
    parameter int unsigned      TMO_W     = 10,
    parameter logic [TMO_W-1:0] TMO_MAX   = 10'd1000
) (
    input  logic        cop_clk,
    input  logic        cop_rst_n,
    input  logic        r0_valid,
    input  logic [31:0] r0_insn,
    input  logic [31:0] r0_rs1,
    input  logic [31:0] r0_rs2,
    output logic        r0_ready,
    output logic        r0_wr,
    output logic        r0_err,
    output logic [31:0] r0_rd,
    input  logic        r1_valid,
    input  logic [31:0] r1_insn,
    input  logic [31:0] r1_rs1,
    input  logic [31:0] r1_rs2,
    output logic        r1_ready,
    output logic        r1_wr,
    output logic        r1_err,
    output logic [31:0] r1_rd,
    output logic        cop_valid,
    output logic [31:0] cop_insn,
    output logic [31:0] cop_rs1,
    output logic [31:0] cop_rs2,
    input  logic        cop_ready,
    input  logic        cop_wr,
    input  logic [31:0] cop_rd,
    output logic        cop_srst,
    output logic        arb_busy,
    output logic        arb_gnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RECOV = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic [TMO_W-1:0]   wdog_q, wdog_d;
    logic               recov_q, recov_d;
    logic               pick;

    // Next values of the registered outputs.
    logic               gnt_d, cvld_d, srst_d, busy_d;
    logic [31:0]        insn_d, rs1_d, rs2_d;
    logic               resp_vld, resp_wr, resp_err;
    logic [31:0]        resp_rd;
    logic               r0_ready_d, r0_wr_d, r0_err_d;
    logic               r1_ready_d, r1_wr_d, r1_err_d;
    logic [31:0]        r0_rd_d, r1_rd_d;

    // State register and registered outputs; reset drops any in-flight request silently.
    always_ff @(posedge cop_clk or negedge cop_rst_n) begin
        if (!cop_rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            wdog_q    <= '0;
            recov_q   <= 1'b0;
            arb_gnt   <= 1'b0;
            arb_busy  <= 1'b0;
            cop_valid <= 1'b0;
            cop_srst  <= 1'b0;
            cop_insn  <= '0;
            cop_rs1   <= '0;
            cop_rs2   <= '0;
            r0_ready  <= 1'b0;
            r0_wr     <= 1'b0;
            r0_err    <= 1'b0;
            r0_rd     <= '0;
            r1_ready  <= 1'b0;
            r1_wr     <= 1'b0;
            r1_err    <= 1'b0;
            r1_rd     <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            wdog_q    <= wdog_d;
            recov_q   <= recov_d;
            arb_gnt   <= gnt_d;
            arb_busy  <= busy_d;
            cop_valid <= cvld_d;
            cop_srst  <= srst_d;
            cop_insn  <= insn_d;
            cop_rs1   <= rs1_d;
            cop_rs2   <= rs2_d;
            r0_ready  <= r0_ready_d;
            r0_wr     <= r0_wr_d;
            r0_err    <= r0_err_d;
            r0_rd     <= r0_rd_d;
            r1_ready  <= r1_ready_d;
            r1_wr     <= r1_wr_d;
            r1_err    <= r1_err_d;
            r1_rd     <= r1_rd_d;
        end
    end

    // Next-state and next-output decode; the response is routed to the granted port only.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        wdog_d   = wdog_q;
        recov_d  = recov_q;
        gnt_d    = arb_gnt;
        insn_d   = cop_insn;
        rs1_d    = cop_rs1;
        rs2_d    = cop_rs2;
        cvld_d   = 1'b0;
        srst_d   = 1'b0;
        pick     = 1'b0;
        resp_vld = 1'b0;
        resp_wr  = 1'b0;
        resp_err = 1'b0;
        resp_rd  = '0;

        case (state_q)
            IDLE: begin
                if (r0_valid || r1_valid) begin
                    // On a tie the port that was not served last wins.
                    pick   = (r0_valid && r1_valid) ? ~last_q : r1_valid;
                    gnt_d  = pick;
                    insn_d = pick ? r1_insn : r0_insn;
                    rs1_d  = pick ? r1_rs1  : r0_rs1;
                    rs2_d  = pick ? r1_rs2  : r0_rs2;
                    if (insn_d[6:0] == CUSOPCODE) begin
                        state_d = ISSUE;
                    end else begin
                        state_d  = RESP;
                        resp_vld = 1'b1;
                        resp_err = 1'b1;
                    end
                end
            end
            ISSUE: begin
                cvld_d  = 1'b1;
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A result arriving in the timeout cycle still wins over recovery.
                if (cop_ready) begin
                    state_d  = RESP;
                    resp_vld = 1'b1;
                    resp_wr  = cop_wr;
                    resp_rd  = cop_rd;
                end else if (wdog_q == TMO_MAX - 1'b1) begin
                    state_d = RECOV;
                    srst_d  = 1'b1;
                    recov_d = 1'b0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            RECOV: begin
                if (!recov_q) begin
                    recov_d = 1'b1;
                    srst_d  = 1'b1;
                end else begin
                    state_d  = RESP;
                    resp_vld = 1'b1;
                    resp_err = 1'b1;
                end
            end
            RESP: begin
                last_d  = arb_gnt;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 1'b0;
                insn_d  = '0;
                rs1_d   = '0;
                rs2_d   = '0;
            end
        endcase

        busy_d     = (state_d != IDLE);
        r0_ready_d = resp_vld & ~gnt_d;
        r0_wr_d    = r0_ready_d & resp_wr;
        r0_err_d   = r0_ready_d & resp_err;
        r0_rd_d    = r0_ready_d ? resp_rd : 32'd0;
        r1_ready_d = resp_vld & gnt_d;
        r1_wr_d    = r1_ready_d & resp_wr;
        r1_err_d   = r1_ready_d & resp_err;
        r1_rd_d    = r1_ready_d ? resp_rd : 32'd0;
    end

endmodule

// File: tb/tb_cop_arb.sv
// Randomized bench for cop_arb: transaction-level reference timeline, bench-driven coprocessor.
// Latency: checks every cycle against edge offsets from the grant edge.
// Backpressure: requesters hold valid until their ready pulse, as a real requester would.
module tb_cop_arb;

    localparam logic [6:0] CUS = 7'b0001011;
    localparam int         T   = 16;

    logic        cop_clk = 1'b0;
    logic        cop_rst_n = 1'b0;
    logic        vld [2];
    logic [31:0] insn [2];
    logic [31:0] rs1 [2];
    logic [31:0] rs2 [2];
    logic        r0_ready, r0_wr, r0_err, r1_ready, r1_wr, r1_err;
    logic [31:0] r0_rd, r1_rd;
    logic        cop_valid, cop_ready, cop_wr, cop_srst, arb_busy, arb_gnt;
    logic [31:0] cop_insn, cop_rs1, cop_rs2, cop_rd;
    logic [34:0] obs_r [2];
    logic        any_out;

    cop_arb #(.CUSOPCODE(CUS), .TMO_W(10), .TMO_MAX(10'd16)) dut (
        .cop_clk(cop_clk), .cop_rst_n(cop_rst_n),
        .r0_valid(vld[0]), .r0_insn(insn[0]), .r0_rs1(rs1[0]), .r0_rs2(rs2[0]),
        .r0_ready(r0_ready), .r0_wr(r0_wr), .r0_err(r0_err), .r0_rd(r0_rd),
        .r1_valid(vld[1]), .r1_insn(insn[1]), .r1_rs1(rs1[1]), .r1_rs2(rs2[1]),
        .r1_ready(r1_ready), .r1_wr(r1_wr), .r1_err(r1_err), .r1_rd(r1_rd),
        .cop_valid(cop_valid), .cop_insn(cop_insn), .cop_rs1(cop_rs1), .cop_rs2(cop_rs2),
        .cop_ready(cop_ready), .cop_wr(cop_wr), .cop_rd(cop_rd),
        .cop_srst(cop_srst), .arb_busy(arb_busy), .arb_gnt(arb_gnt)
    );

    always #5 cop_clk = ~cop_clk;

    assign obs_r[0] = {r0_ready, r0_wr, r0_err, r0_rd};
    assign obs_r[1] = {r1_ready, r1_wr, r1_err, r1_rd};
    assign any_out  = |{r0_ready, r0_wr, r0_err, r0_rd, r1_ready, r1_wr, r1_err, r1_rd,
                        cop_valid, cop_insn, cop_rs1, cop_rs2, cop_srst, arb_busy, arb_gnt};

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one transaction in flight, timed in edges since its grant edge.
    bit          inflight, cooldown, m_last, m_gnt, m_port, m_custom;
    int          t, ans_d;             // ans_d == 0: coprocessor never answers
    logic [31:0] m_insn, m_rs1, m_rs2, ans_rd;
    logic        ans_wr;
    int          remaining [2];
    bit          cont [2];
    int          force_d, op_mode;
    int          dut_rdy [2];
    bit          gq [$];

    function automatic logic [31:0] gen_insn();
        logic [31:0] w;
        w = $urandom;
        if (op_mode == 1 || (op_mode == 0 && $urandom_range(0, 3) != 0)) w[6:0] = CUS;
        else if (op_mode == 2) w[6:0] = 7'b0110011;
        else if (w[6:0] == CUS) w[6:0] = 7'b0010011;
        return w;
    endfunction

    function automatic int pick_delay();
        int r;
        if (force_d >= 0) return force_d;
        if (force_d == -2) return int'($urandom_range(1, 6));
        r = int'($urandom_range(0, 7));
        if (r == 0) return 0;
        if (r == 1) return T;
        return int'($urandom_range(1, T - 1));
    endfunction

    task automatic step();
        bit          resp, exp_cv, exp_srst, exp_busy, allowed;
        logic        resp_wr, resp_err;
        logic [31:0] resp_rd;
        logic [34:0] exp_r;
        @(posedge cop_clk);
        #1;
        resp = 0; resp_wr = 0; resp_err = 0; resp_rd = '0; exp_cv = 0; exp_srst = 0;
        if (inflight) t++;
        else if (cooldown) cooldown = 0;
        else if (vld[0] || vld[1]) begin
            m_port   = (vld[0] && vld[1]) ? ~m_last : vld[1];
            m_gnt    = m_port;
            inflight = 1;
            t        = 0;
            m_insn   = insn[m_port];
            m_rs1    = rs1[m_port];
            m_rs2    = rs2[m_port];
            m_custom = (m_insn[6:0] == CUS);
            ans_d    = pick_delay();
            ans_wr   = 1'($urandom);
            ans_rd   = $urandom;
            gq.push_back(arb_gnt);
        end
        if (inflight) begin
            if (!m_custom) begin
                if (t == 0) begin resp = 1; resp_err = 1; end
            end else begin
                if (t == 1) exp_cv = 1;
                if (ans_d != 0 && t == 1 + ans_d) begin resp = 1; resp_wr = ans_wr; resp_rd = ans_rd; end
                if (ans_d == 0 && (t == T + 1 || t == T + 2)) exp_srst = 1;
                if (ans_d == 0 && t == T + 3) begin resp = 1; resp_err = 1; end
            end
        end
        exp_busy = inflight;
        for (int p = 0; p < 2; p++) begin
            exp_r = (resp && int'(m_port) == p) ? {1'b1, resp_wr, resp_err, resp_rd} : 35'd0;
            check($sformatf("r%0d_resp", p), 64'(obs_r[p]), 64'(exp_r));
            if (obs_r[p][34]) dut_rdy[p]++;
        end
        check("cop_valid", 64'(cop_valid), 64'(exp_cv));
        if (exp_cv) begin
            check("cop_insn_rs1", {cop_insn, cop_rs1}, {m_insn, m_rs1});
            check("cop_rs2", 64'(cop_rs2), 64'(m_rs2));
        end
        check("cop_srst", 64'(cop_srst), 64'(exp_srst));
        check("arb_busy", 64'(arb_busy), 64'(exp_busy));
        check("arb_gnt", 64'(arb_gnt), 64'(m_gnt));
        if (resp) begin inflight = 0; cooldown = 1; m_last = m_port; end

        // Coprocessor: answer on schedule; stray pulses only where the arbiter must ignore them.
        if (inflight && m_custom && ans_d != 0 && t + 1 == 1 + ans_d) begin
            cop_ready = 1; cop_wr = ans_wr; cop_rd = ans_rd;
        end else begin
            allowed   = !inflight || !m_custom || (t + 1 < 2) || (ans_d == 0 && t + 1 > T + 1);
            cop_wr    = 1'($urandom);
            cop_rd    = $urandom;
            cop_ready = allowed && ($urandom_range(0, 3) == 0);
        end

        // Requesters: drop valid on the ready edge, then maybe raise the next request.
        for (int p = 0; p < 2; p++) begin
            if (resp && int'(m_port) == p) vld[p] = 0;
            if (!vld[p] && remaining[p] > 0 && (cont[p] || $urandom_range(0, 2) == 0)) begin
                vld[p]  = 1;
                insn[p] = gen_insn();
                rs1[p]  = $urandom;
                rs2[p]  = $urandom;
                remaining[p]--;
            end
        end
    endtask

    task automatic model_reset();
        inflight = 0; cooldown = 0; m_last = 1; m_gnt = 0; t = 0;
    endtask

    task automatic do_reset();
        cop_rst_n = 0;
        vld[0] = 0; vld[1] = 0; cop_ready = 0;
        remaining[0] = 0; remaining[1] = 0;
        #1 check("reset_outs", 64'(any_out), 64'd0);
        repeat (2) @(negedge cop_clk);
        cop_rst_n = 1;
        model_reset();
    endtask

    task automatic run(input string tag, input int n0, input int n1, input bit c0, input bit c1,
                       input int fd, input int om);
        int budget = 3000;
        int base0 = dut_rdy[0];
        int base1 = dut_rdy[1];
        remaining[0] = n0; remaining[1] = n1; cont[0] = c0; cont[1] = c1;
        force_d = fd; op_mode = om;
        while ((remaining[0] > 0 || remaining[1] > 0 || vld[0] || vld[1] || inflight || cooldown)
               && budget > 0) begin
            step();
            budget--;
        end
        check({tag, "_done"}, 64'(budget > 0), 64'd1);
        check({tag, "_r0_count"}, 64'(dut_rdy[0] - base0), 64'(n0));
        check({tag, "_r1_count"}, 64'(dut_rdy[1] - base1), 64'(n1));
    endtask

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vld[0] = 0; vld[1] = 0;
        for (int p = 0; p < 2; p++) begin
            insn[p] = '0; rs1[p] = '0; rs2[p] = '0; remaining[p] = 0; cont[p] = 0; dut_rdy[p] = 0;
        end
        cop_ready = 0; cop_wr = 0; cop_rd = '0;
        force_d = -1; op_mode = 0;
        model_reset();

        // Single custom request answered after 5 cycles.
        do_reset();
        run("p1", 1, 0, 1'b1, 1'b0, 5, 1);

        // Both requesting continuously from reset: grants must alternate starting with r0.
        do_reset();
        gq.delete();
        run("p2", 4, 4, 1'b1, 1'b1, -2, 1);
        check("p2_grants", 64'(gq.size()), 64'd8);
        for (int i = 0; i < gq.size(); i++) check($sformatf("p2_order%0d", i), 64'(gq[i]), 64'(i % 2));

        // Rejected opcode on r1, coprocessor never answers, answer exactly at timeout.
        run("p3", 0, 1, 1'b1, 1'b1, -1, 2);
        run("p4", 1, 0, 1'b1, 1'b0, 0, 1);
        run("p5", 1, 0, 1'b1, 1'b0, T, 1);

        // Asynchronous reset in the middle of WAIT, then a late result that must be ignored.
        remaining[0] = 1; cont[0] = 1; force_d = 0; op_mode = 1;
        for (int i = 0; i < 100 && !(inflight && t == 5); i++) step();
        check("p6_in_wait", 64'(inflight && t == 5), 64'd1);
        #2 cop_rst_n = 0;
        #1 check("p6_arst_outs", 64'(any_out), 64'd0);
        vld[0] = 0; remaining[0] = 0;
        cop_ready = 1; cop_wr = 1; cop_rd = 32'hdead_beef;
        @(posedge cop_clk);
        #1 check("p6_arst_hold", 64'(any_out), 64'd0);
        @(negedge cop_clk);
        cop_rst_n = 1;
        model_reset();
        repeat (3) step();
        run("p6", 1, 0, 1'b1, 1'b0, 3, 1);

        // Random mix of ports, opcodes and coprocessor delays.
        run("p7", 20, 20, 1'b0, 1'b0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
